// File: rtl/pipe_stall_responder.sv
// IF-stage PC / IF-ID register controller that reacts to load-use stalls and ID-resolved flushes.
// It also tracks stall statistics and raises a sticky error when a stall runs longer than MAX_STALL cycles.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_RUN   | last edge advanced the pipe normally (or reset)
// ST_STALL | last edge held PC and IF/ID for a load-use stall
// ST_FLUSH | last edge redirected PC and squashed IF/ID
module pipe_stall_responder #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        id_ex_bubble_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic        stall_err_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [3:0] MAX_STALL_C = 4'(MAX_STALL);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [3:0]  consec_q, consec_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_err_q, stall_err_d;

  always_comb begin
    state_d       = ST_RUN;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    consec_d      = 4'd0;
    stall_cnt_d   = stall_cnt_q;
    stall_err_d   = stall_err_q;

    // A flush wins over a coincident stall: the stalled instruction is squashed anyway.
    if (flush_i) begin
      state_d       = ST_FLUSH;
      pc_d          = branch_target_i;
      if_id_pc_d    = 32'h0;
      if_id_instr_d = 32'h0;
      if_id_valid_d = 1'b0;
    end else if (stall_i) begin
      state_d = ST_STALL;
      if (consec_q == MAX_STALL_C) stall_err_d = 1'b1;
      consec_d = (consec_q == 4'hF) ? 4'hF : consec_q + 4'd1;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      pc_d          = pc_q + 32'd4;
      if_id_pc_d    = pc_q;
      if_id_instr_d = instr_i;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
      consec_q      <= 4'd0;
      stall_cnt_q   <= 16'd0;
      stall_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      consec_q      <= consec_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_err_q   <= stall_err_d;
    end
  end

  assign pc_o           = pc_q;
  assign if_id_pc_o     = if_id_pc_q;
  assign if_id_instr_o  = if_id_instr_q;
  assign if_id_valid_o  = if_id_valid_q;
  assign id_ex_bubble_o = stall_i | ~if_id_valid_q;
  assign state_o        = state_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign stall_err_o    = stall_err_q;

endmodule

// File: tb/tb_pipe_stall_responder.sv
// Directed bench for pipe_stall_responder: an abstract per-edge model is compared on every
// falling edge, and literal expectations at key points pin the model itself.
module tb_pipe_stall_responder;
  localparam int MAX_STALL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [31:0] branch_target_i, instr_i;
  logic [31:0] pc_o, if_id_pc_o, if_id_instr_o;
  logic        if_id_valid_o, id_ex_bubble_o, stall_err_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  pipe_stall_responder #(.RESET_PC(32'h0), .MAX_STALL(MAX_STALL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .instr_i(instr_i),
    .pc_o(pc_o), .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o), .id_ex_bubble_o(id_ex_bubble_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o), .stall_err_o(stall_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: pipeline contents described directly from the priority rules.
  bit      m_ok = 1'b0;
  longint  m_pc;
  longint  m_ifid_pc, m_ifid_instr;
  bit      m_valid, m_err;
  int      m_state;   // 0 run, 1 stall, 2 flush
  int      m_run;     // consecutive stall cycles so far
  int      m_total;   // stall cycles since reset

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_ok = 1'b1; m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
      m_err = 0; m_state = 0; m_run = 0; m_total = 0;
    end else if (m_ok) begin
      if (flush_i) begin
        m_pc = branch_target_i; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
        m_state = 2; m_run = 0;
      end else if (stall_i) begin
        if (m_run == MAX_STALL) m_err = 1;
        if (m_run < 15) m_run++;
        if (m_total < 65535) m_total++;
        m_state = 1;
      end else begin
        m_ifid_pc = m_pc; m_ifid_instr = instr_i; m_valid = 1;
        m_pc = (m_pc + 4) % 64'h1_0000_0000;
        m_state = 0; m_run = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_ok) begin
      chk("pc", pc_o, 32'(m_pc));
      chk("ifid_pc", if_id_pc_o, 32'(m_ifid_pc));
      chk("ifid_instr", if_id_instr_o, 32'(m_ifid_instr));
      chk("ifid_valid", 32'(if_id_valid_o), 32'(m_valid));
      chk("bubble", 32'(id_ex_bubble_o), 32'(stall_i | !m_valid));
      chk("state", 32'(state_o), 32'(m_state));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_total));
      chk("stall_err", 32'(stall_err_o), 32'(m_err));
    end
  end

  // Apply inputs for one rising edge; returns 1 time unit after that edge.
  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [31:0] tgt, input logic [31:0] ins);
    rst_i = r; stall_i = s; flush_i = f; branch_target_i = tgt; instr_i = ins;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b0; branch_target_i = 32'h0; instr_i = 32'h0;
    drive(1, 1, 0, 32'h0, 32'h0);
    drive(1, 0, 1, 32'h100, 32'hDEAD_BEEF);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", 32'(if_id_valid_o), 32'h0);
    chk("rst_state", 32'(state_o), 32'h0);
    chk("rst_bubble", 32'(id_ex_bubble_o), 32'h1);

    // Normal advance
    drive(0, 0, 0, 32'h0, 32'h2002_0005);
    chk("adv_pc4", pc_o, 32'h4);
    chk("adv_instr", if_id_instr_o, 32'h2002_0005);
    chk("adv_ifid_pc", if_id_pc_o, 32'h0);
    chk("adv_valid", 32'(if_id_valid_o), 32'h1);
    drive(0, 0, 0, 32'h0, 32'h2002_0005);
    chk("adv_pc8", pc_o, 32'h8);

    // Single stall at pc 8
    stall_i = 1'b1; #1;
    chk("stall_bubble", 32'(id_ex_bubble_o), 32'h1);
    drive(0, 1, 0, 32'h0, 32'h1111_1111);
    chk("stall_pc", pc_o, 32'h8);
    chk("stall_ifid_pc", if_id_pc_o, 32'h4);
    chk("stall_state", 32'(state_o), 32'h1);
    chk("stall_cnt1", 32'(stall_cnt_o), 32'h1);
    drive(0, 0, 0, 32'h0, 32'h2222_2222);
    chk("stall_after_pc", pc_o, 32'hC);

    // Flush over stall
    drive(0, 1, 1, 32'h40, 32'h3333_3333);
    chk("flush_pc", pc_o, 32'h40);
    chk("flush_valid", 32'(if_id_valid_o), 32'h0);
    chk("flush_state", 32'(state_o), 32'h2);
    chk("flush_cnt", 32'(stall_cnt_o), 32'h1);
    drive(0, 0, 0, 32'h0, 32'h4444_4444);
    chk("post_flush_ifid_pc", if_id_pc_o, 32'h40);

    // Stall limit: MAX_STALL+1 consecutive stalls
    for (int i = 1; i <= MAX_STALL + 1; i++) begin
      drive(0, 1, 0, 32'h0, 32'h0);
      chk("limit_err", 32'(stall_err_o), (i == MAX_STALL + 1) ? 32'h1 : 32'h0);
    end
    drive(0, 0, 0, 32'h0, 32'h5);
    drive(0, 0, 0, 32'h0, 32'h6);
    chk("err_sticky", 32'(stall_err_o), 32'h1);
    chk("limit_cnt", 32'(stall_cnt_o), 32'h6);

    // Broken stall runs never accumulate to an error
    drive(1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < MAX_STALL; k++) drive(0, 1, 0, 32'h0, 32'h0);
      drive(0, 0, 0, 32'h0, 32'h7);
    end
    chk("no_err_short_runs", 32'(stall_err_o), 32'h0);

    // Reset mid-stall with stall_cnt 3
    drive(1, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h8);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 32'h0, 32'h0);
    chk("pre_rst_cnt", 32'(stall_cnt_o), 32'h3);
    drive(1, 1, 0, 32'h0, 32'h0);
    chk("rst_mid_pc", pc_o, 32'h0);
    chk("rst_mid_cnt", 32'(stall_cnt_o), 32'h0);
    chk("rst_mid_state", 32'(state_o), 32'h0);
    chk("rst_mid_ifid", if_id_instr_o, 32'h0);

    // Reset mid-flush, then consecutive count restarts from zero
    drive(0, 0, 1, 32'h80, 32'h0);
    drive(1, 0, 1, 32'h90, 32'h0);
    chk("rst_flush_pc", pc_o, 32'h0);
    for (int i = 0; i < MAX_STALL; i++) drive(0, 1, 0, 32'h0, 32'h0);
    chk("rst_clears_run", 32'(stall_err_o), 32'h0);

    // PC wrap
    drive(0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h9);
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_ifid_pc", if_id_pc_o, 32'hFFFF_FFFC);

    // Saturation of the total stall counter
    drive(1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 65534; i++) drive(0, 1, 0, 32'h0, 32'h0);
    chk("sat_fffe", 32'(stall_cnt_o), 32'hFFFE);
    drive(0, 1, 0, 32'h0, 32'h0);
    chk("sat_ffff_1", 32'(stall_cnt_o), 32'hFFFF);
    drive(0, 1, 0, 32'h0, 32'h0);
    chk("sat_ffff_2", 32'(stall_cnt_o), 32'hFFFF);
    drive(0, 0, 0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_responder.md
PIPE_STALL_RESPONDER -- requirements
Module: pipe_stall_responder

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter MAX_STALL, default 4: consecutive stall-cycle limit before an error is flagged; legal range 1..15.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall_i  input  1  load-use stall request from the hazard detection unit; 1 = hold PC and IF/ID.
REQ-006 SHALL have port flush_i  input  1  taken branch or jump resolved in ID; 1 = redirect PC and squash IF/ID.
REQ-007 SHALL have port branch_target_i  input  32  redirect address, sampled when flush_i=1.
REQ-008 SHALL have port instr_i  input  32  instruction fetched from instruction memory at pc_o.
REQ-009 SHALL have port pc_o  output  32  current fetch PC.
REQ-010 SHALL have port if_id_pc_o  output  32  PC of the instruction held in IF/ID.
REQ-011 SHALL have port if_id_instr_o  output  32  instruction held in IF/ID.
REQ-012 SHALL have port if_id_valid_o  output  1  1 = IF/ID holds a real instruction.
REQ-013 SHALL have port id_ex_bubble_o  output  1  1 = ID stage must drive all ID/EX control fields to zero this cycle.
REQ-014 SHALL have port state_o  output  2  FSM state: 2'b00 RUN, 2'b01 STALL, 2'b10 FLUSH.
REQ-015 SHALL have port stall_cnt_o  output  16  total stall cycles since reset, saturating.
REQ-016 SHALL have port stall_err_o  output  1  sticky flag: stall_i held beyond MAX_STALL consecutive cycles.

Function
REQ-017 SHALL apply priority rst_i > flush_i > stall_i > normal advance at every rising edge.
REQ-018 SHALL update pc_o as follows: flush_i=1 -> branch_target_i; stall_i=1 -> hold; otherwise pc_o+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-019 SHALL load IF/ID on flush_i=1 with instr=32'h0 (NOP), pc=32'h0, valid=0.
REQ-020 SHALL hold IF/ID (instr, pc, valid) unchanged when stall_i=1 and flush_i=0.
REQ-021 SHALL otherwise load IF/ID with instr_i, the current pc_o and valid=1, giving exactly one cycle of fetch-to-ID latency.
REQ-022 SHALL drive id_ex_bubble_o combinationally as stall_i OR NOT if_id_valid_o, with zero-cycle latency.
REQ-023 SHALL register the FSM next state each cycle as FLUSH if flush_i, else STALL if stall_i, else RUN; any state may reach any state in one cycle.
REQ-024 SHALL keep a 4-bit consecutive-stall counter: increment (saturating at 15) on each cycle with stall_i=1 and flush_i=0; clear to 0 on any other cycle.
REQ-025 SHALL set stall_err_o when stall_i=1 and flush_i=0 and the consecutive counter already equals MAX_STALL; once set it remains 1 until reset.
REQ-026 SHALL increment stall_cnt_o on each cycle with stall_i=1 and flush_i=0, and hold it at 16'hFFFF once reached.
REQ-027 SHALL treat simultaneous flush_i=1 and stall_i=1 as a flush: no stall count, the consecutive counter clears, and the next state is FLUSH.

Reset
REQ-028 SHALL on rst_i=1 at a clock edge set pc_o=RESET_PC, if_id_instr_o=32'h0, if_id_pc_o=32'h0, if_id_valid_o=0, state_o=RUN, stall_cnt_o=0, consecutive counter=0 and stall_err_o=0, regardless of other inputs.
REQ-029 SHALL give id_ex_bubble_o=1 during and immediately after reset, because if_id_valid_o=0.
REQ-030 SHALL, on reset asserted mid-stall or mid-flush, discard the in-progress operation with no residual effect.

Verification
REQ-031 Normal advance: reset released with instr_i=32'h2002_0005 -> pc_o sequence 0, 4, 8; first edge after reset gives if_id_instr_o=32'h2002_0005, if_id_pc_o=0, valid=1.
REQ-032 Single stall at pc_o=8: stall_i=1 for one cycle -> pc_o stays 8 and IF/ID holds; id_ex_bubble_o=1 that cycle; state_o=STALL; stall_cnt_o=1; pc_o=12 on the following edge.
REQ-033 Flush over stall: stall_i=1, flush_i=1, branch_target_i=32'h40 -> pc_o=32'h40, if_id_valid_o=0, state_o=FLUSH, stall_cnt_o unchanged.
REQ-034 Stall limit: stall_i held for MAX_STALL+1=5 cycles -> stall_err_o rises on the 5th edge and stays 1 after stall_i drops, until rst_i.
REQ-035 Wrap and saturation: pc_o=32'hFFFF_FFFC with no stall -> pc_o=0; with stall_cnt_o forced to 16'hFFFE, two further stalls -> 16'hFFFF, 16'hFFFF.
REQ-036 Reset mid-stall: rst_i=1 while stall_i=1 and stall_cnt_o=3 -> all outputs take their REQ-028 values on that edge.
